// File: rtl/alm_err_monitor.sv
// -----------------------------------------------------------------------------
// alm_err_monitor
//
// Error-statistics collector for approximate logarithmic multipliers. It accepts
// a valid/ready stream of (x, y, approximate product) samples. For each sample
// it computes the exact product, truncated to PW bits, and the absolute error
// distance. Over a programmed number of samples it accumulates:
//   - the sum of error distances
//   - the count of erroneous samples
//   - the count of nonzero exact products
//   - the worst-case error, with its operands and products
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state and the accepted-sample counter, never
// on in_valid. The producer may hold or drop in_valid at will.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, n_samples    begin a run (ignored while busy); n_samples latched
//   in_valid/in_ready   sample handshake
//   in_x, in_y, in_p    operands and approximate product
//   busy, done          run in progress / results final
//   sum_ed .. max_approx  statistics
//   dbg_state           current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
// -----------------------------------------------------------------------------
module alm_err_monitor #(
  parameter int OPW  = 9,
  parameter int PW   = 17,
  parameter int CNTW = 20,
  parameter int ACCW = 37
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CNTW-1:0] n_samples,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_x,
  input  logic [OPW-1:0]  in_y,
  input  logic [PW-1:0]   in_p,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] sum_ed,
  output logic [CNTW-1:0] err_cnt,
  output logic [CNTW-1:0] nz_cnt,
  output logic [PW-1:0]   max_ed,
  output logic [OPW-1:0]  max_x,
  output logic [OPW-1:0]  max_y,
  output logic [PW-1:0]   max_exact,
  output logic [PW-1:0]   max_approx,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] n_q;
  logic [CNTW-1:0] acc_q;

  // S1 registers
  logic            s1_v_q;
  logic [OPW-1:0]  s1_x_q, s1_y_q;
  logic [PW-1:0]   s1_p_q, s1_exact_q;
  // S2 registers
  logic            s2_v_q;
  logic [OPW-1:0]  s2_x_q, s2_y_q;
  logic [PW-1:0]   s2_p_q, s2_exact_q, s2_ed_q;
  // Statistics registers
  logic [ACCW-1:0] sum_q;
  logic [CNTW-1:0] err_q, nz_q;
  logic [PW-1:0]   max_ed_q, max_exact_q, max_approx_q;
  logic [OPW-1:0]  max_x_q, max_y_q;

  logic            start_acc;
  logic            hs;
  logic            last_hs;
  logic [PW-1:0]   exact_w;
  logic [PW:0]     diff_w;
  logic [PW-1:0]   ed_w;

  // Start only counts when no run is in progress.
  assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_ready  = (state_q == ST_RUN) && (acc_q < n_q);
  assign hs        = in_valid && in_ready;
  // acc_q < n_q whenever hs is high, so acc_q + 1 cannot wrap.
  assign last_hs   = hs && ((acc_q + CNTW'(1)) == n_q);

  // A PW-bit multiply yields the exact product already truncated to PW bits.
  assign exact_w = PW'(in_x) * PW'(in_y);

  // Subtract at PW+1 bits; the borrow bit selects the order of the operands,
  // so the magnitude always fits in PW bits.
  assign diff_w = {1'b0, s1_p_q} - {1'b0, s1_exact_q};
  assign ed_w   = diff_w[PW] ? (s1_exact_q - s1_p_q) : diff_w[PW-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (n_samples == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (last_hs) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_v_q && !s2_v_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      acc_q        <= '0;
      s1_v_q       <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_p_q       <= '0;
      s1_exact_q   <= '0;
      s2_v_q       <= 1'b0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      s2_p_q       <= '0;
      s2_exact_q   <= '0;
      s2_ed_q      <= '0;
      sum_q        <= '0;
      err_q        <= '0;
      nz_q         <= '0;
      max_ed_q     <= '0;
      max_x_q      <= '0;
      max_y_q      <= '0;
      max_exact_q  <= '0;
      max_approx_q <= '0;
    end else begin
      state_q <= state_d;

      if (start_acc) begin
        n_q   <= n_samples;
        acc_q <= '0;
      end else if (hs) begin
        acc_q <= acc_q + CNTW'(1);
      end

      // S1: capture the sample and its exact product.
      s1_v_q <= hs;
      if (hs) begin
        s1_x_q     <= in_x;
        s1_y_q     <= in_y;
        s1_p_q     <= in_p;
        s1_exact_q <= exact_w;
      end

      // S2: error distance.
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_x_q     <= s1_x_q;
        s2_y_q     <= s1_y_q;
        s2_p_q     <= s1_p_q;
        s2_exact_q <= s1_exact_q;
        s2_ed_q    <= ed_w;
      end

      // S3: commit statistics. The pipeline is empty whenever start is
      // accepted, so clearing and committing never collide.
      if (start_acc) begin
        sum_q        <= '0;
        err_q        <= '0;
        nz_q         <= '0;
        max_ed_q     <= '0;
        max_x_q      <= '0;
        max_y_q      <= '0;
        max_exact_q  <= '0;
        max_approx_q <= '0;
      end else if (s2_v_q) begin
        sum_q <= sum_q + ACCW'(s2_ed_q);
        if (s2_ed_q != '0)    err_q <= err_q + CNTW'(1);
        if (s2_exact_q != '0) nz_q  <= nz_q + CNTW'(1);
        // Strict compare: on a tie the earlier sample stays recorded.
        if (s2_ed_q > max_ed_q) begin
          max_ed_q     <= s2_ed_q;
          max_x_q      <= s2_x_q;
          max_y_q      <= s2_y_q;
          max_exact_q  <= s2_exact_q;
          max_approx_q <= s2_p_q;
        end
      end
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign sum_ed     = sum_q;
  assign err_cnt    = err_q;
  assign nz_cnt     = nz_q;
  assign max_ed     = max_ed_q;
  assign max_x      = max_x_q;
  assign max_y      = max_y_q;
  assign max_exact  = max_exact_q;
  assign max_approx = max_approx_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alm_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_alm_err_monitor
//
// Directed stimulus with a behavioural reference model. The model follows
// the documented behaviour:
//   - a start is seen one edge later
//   - an accepted sample's statistics appear two edges after acceptance
//   - done rises one edge after the last commit
// A single negedge process compares every DUT output against the model on every
// cycle after the first reset. Literal expectations, worked out by hand, pin
// the results of each scenario.
// -----------------------------------------------------------------------------
module tb_alm_err_monitor;

  localparam int OPW  = 9;
  localparam int PW   = 17;
  localparam int CNTW = 20;
  localparam int ACCW = 37;

  // ---------------- clock / reset ----------------
  logic            clk;
  logic            rst_n;
  logic            start;
  logic [CNTW-1:0] n_samples;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_x, in_y;
  logic [PW-1:0]   in_p;
  logic            busy, done;
  logic [ACCW-1:0] sum_ed;
  logic [CNTW-1:0] err_cnt, nz_cnt;
  logic [PW-1:0]   max_ed, max_exact, max_approx;
  logic [OPW-1:0]  max_x, max_y;
  logic [1:0]      dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alm_err_monitor #(.OPW(OPW), .PW(PW), .CNTW(CNTW), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_p(in_p), .busy(busy), .done(done), .sum_ed(sum_ed),
    .err_cnt(err_cnt), .nz_cnt(nz_cnt), .max_ed(max_ed), .max_x(max_x),
    .max_y(max_y), .max_exact(max_exact), .max_approx(max_approx),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int x;
    int y;
    int p;
    int due;
  } smp_t;

  smp_t   pend_q[$];
  bit     m_on = 0;
  bit     m_busy = 0, m_done = 0;
  int     m_n = 0, m_acc = 0;
  longint m_sum = 0;
  int     m_err = 0, m_nz = 0, m_max_ed = 0;
  int     m_max_x = 0, m_max_y = 0, m_max_exact = 0, m_max_approx = 0;
  bit     rst_pend = 0, st_pend = 0;
  int     rst_due = 0, st_due = 0, st_n = 0, done_due = -1;
  int     hs_cnt = 0;

  function automatic void clear_stats();
    m_sum = 0; m_err = 0; m_nz = 0; m_max_ed = 0;
    m_max_x = 0; m_max_y = 0; m_max_exact = 0; m_max_approx = 0;
  endfunction

  function automatic void commit(input smp_t s);
    int exact, ed;
    exact = (s.x * s.y) % 131072;
    ed    = (s.p > exact) ? s.p - exact : exact - s.p;
    m_sum += ed;
    if (ed != 0)    m_err++;
    if (exact != 0) m_nz++;
    if (ed > m_max_ed) begin
      m_max_ed = ed; m_max_x = s.x; m_max_y = s.y;
      m_max_exact = exact; m_max_approx = s.p;
    end
  endfunction

  always @(negedge clk) begin
    smp_t s;
    if (rst_pend && rst_due == cyc) begin
      rst_pend = 0; st_pend = 0; done_due = -1;
      pend_q.delete();
      clear_stats();
      m_busy = 0; m_done = 0; m_n = 0; m_acc = 0; m_on = 1;
    end
    if (st_pend && st_due == cyc) begin
      st_pend = 0;
      clear_stats();
      m_n = st_n; m_acc = 0;
      m_busy = (st_n != 0);
      m_done = (st_n == 0);
    end
    while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      s = pend_q.pop_front();
      commit(s);
    end
    if (done_due == cyc) begin
      m_busy = 0; m_done = 1; done_due = -1;
    end

    if (m_on) begin
      chk("in_ready",   in_ready,   longint'(m_busy && (m_acc < m_n)));
      chk("busy",       busy,       longint'(m_busy));
      chk("done",       done,       longint'(m_done));
      chk("sum_ed",     sum_ed,     m_sum);
      chk("err_cnt",    err_cnt,    m_err);
      chk("nz_cnt",     nz_cnt,     m_nz);
      chk("max_ed",     max_ed,     m_max_ed);
      chk("max_x",      max_x,      m_max_x);
      chk("max_y",      max_y,      m_max_y);
      chk("max_exact",  max_exact,  m_max_exact);
      chk("max_approx", max_approx, m_max_approx);
    end

    if (!rst_n) begin
      rst_pend = 1; rst_due = cyc + 1;
    end else begin
      if (in_valid && in_ready) begin
        hs_cnt++;
        m_acc++;
        s.x = int'(in_x); s.y = int'(in_y); s.p = int'(in_p); s.due = cyc + 3;
        pend_q.push_back(s);
        if (m_acc == m_n) done_due = cyc + 4;
      end
      if (start && !m_busy && !st_pend) begin
        st_pend = 1; st_due = cyc + 1; st_n = int'(n_samples);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1; n_samples = CNTW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int p, input int max_gap);
    bit ok;
    int gap;
    gap = int'($urandom_range(max_gap, 0));
    for (int g = 0; g < gap; g++) begin
      in_x = OPW'($urandom_range(511, 0)); // junk while in_valid is low
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_x = OPW'(x); in_y = OPW'(y); in_p = PW'(p);
    ok = 0;
    for (int b = 0; b < 50 && !ok; b++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1;
      end
    end
    if (!ok) begin
      in_valid = 1'b0;
      chk("handshake_timeout", 0, 1);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int b = 0; b < 30 && !seen; b++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_reached", seen, 1);
  endtask

  // ---------------- scenarios ----------------
  int hs_base;

  initial begin
    rst_n = 1'b0; start = 1'b0; n_samples = '0; in_valid = 1'b0;
    in_x = '0; in_y = '0; in_p = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_done",  done, 0);
    rst_n = 1'b1;

    // Exact sample, no error.
    do_start(1);
    send(200, 100, 20000, 0);
    wait_done();
    chk("t1_sum", sum_ed, 0);
    chk("t1_err", err_cnt, 0);
    chk("t1_nz",  nz_cnt, 1);
    chk("t1_max", max_ed, 0);

    // Three erroneous samples, one with a zero exact product.
    do_start(3);
    send(10, 10, 90, 0);
    send(255, 255, 65000, 0);
    send(0, 7, 3, 0);
    wait_done();
    chk("t2_sum",   sum_ed, 38);
    chk("t2_err",   err_cnt, 3);
    chk("t2_nz",    nz_cnt, 2);
    chk("t2_max",   max_ed, 25);
    chk("t2_maxx",  max_x, 255);
    chk("t2_maxy",  max_y, 255);
    chk("t2_maxe",  max_exact, 65025);
    chk("t2_maxa",  max_approx, 65000);

    // Tie on max error keeps the first sample.
    do_start(2);
    send(4, 4, 14, 1);
    send(2, 3, 4, 1);
    wait_done();
    chk("t3_max",  max_ed, 2);
    chk("t3_maxx", max_x, 4);
    chk("t3_maxy", max_y, 4);
    chk("t3_maxa", max_approx, 14);
    chk("t3_sum",  sum_ed, 4);

    // Empty run.
    do_start(0);
    chk("t4_done",  done, 1);
    chk("t4_ready", in_ready, 0);
    chk("t4_sum",   sum_ed, 0);
    chk("t4_max",   max_ed, 0);
    chk("t4_nz",    nz_cnt, 0);
    repeat (2) @(posedge clk);
    #1;

    // Gaps, truncated product, and an ignored mid-run start.
    hs_base = hs_cnt;
    do_start(5);
    send(3, 5, 15, 3);
    send(7, 7, 50, 3);
    @(posedge clk); #1;
    start = 1'b1; n_samples = CNTW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    send(9, 9, 80, 3);
    send(511, 511, 0, 3);
    send(100, 3, 299, 3);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_ready_after_last", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    chk("t5_handshakes", hs_cnt - hs_base, 5);
    chk("t5_sum",  sum_ed, 130052);
    chk("t5_err",  err_cnt, 4);
    chk("t5_nz",   nz_cnt, 5);
    chk("t5_max",  max_ed, 130049);
    chk("t5_maxx", max_x, 511);
    chk("t5_maxe", max_exact, 130049);
    chk("t5_maxa", max_approx, 0);

    // Reset in the middle of a run.
    do_start(5);
    send(6, 6, 40, 0);
    send(8, 8, 60, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_state", dbg_state, 0);
    chk("t6_busy",  busy, 0);
    chk("t6_sum",   sum_ed, 0);
    chk("t6_err",   err_cnt, 0);
    chk("t6_max",   max_ed, 0);
    do_start(1);
    send(12, 12, 150, 0);
    wait_done();
    chk("t6_sum2", sum_ed, 6);
    chk("t6_err2", err_cnt, 1);
    chk("t6_max2", max_ed, 6);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alm_err_monitor.md
# alm_err_monitor

Synthesizable error-statistics collector for the approximate logarithmic multipliers. It is the checking end of the multiplier evaluation flow: it consumes a valid/ready stream of (x, y, approximate product) samples and computes the exact product for each one. It accumulates the absolute error distance, the count of erroneous samples, the count of nonzero exact products and the worst-case error with its operands, over a programmed number of samples. AE, NMED and MRED-style figures are derived off-chip from the reported totals.

## Interface
- OPW, 9, operand width (unsigned)
- PW, 17, product width; exact product is truncated to PW bits
- CNTW, 20, sample-counter width
- ACCW, 37, error-sum accumulator width (≥ PW+CNTW)

- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run with n_samples
- n_samples  in  CNTW  samples to accept; sampled on start
- in_valid  in  1  sample valid
- in_ready  out  1  monitor can accept a sample
- in_x, in_y  in  OPW  operands
- in_p  in  PW  approximate product from the multiplier under test
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  results final; held until next accepted start or reset
- sum_ed  out  ACCW  Σ|p − exact|
- err_cnt  out  CNTW  samples with p ≠ exact
- nz_cnt  out  CNTW  samples with exact ≠ 0
- max_ed  out  PW  largest error distance
- max_x, max_y  out  OPW  operands of the max_ed sample
- max_exact, max_approx  out  PW  exact and approximate products of the max_ed sample

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch n_samples; clear all statistics, counters and done. If n_samples = 0, go to DONE; otherwise go to RUN.
- start while in RUN or DRAIN is ignored.
- RUN: in_ready = 1 while accepted < n_samples. A handshake is in_valid && in_ready. When the last sample is accepted, go to DRAIN.
- DRAIN: in_ready = 0. Wait until the pipeline is empty, then go to DONE.
- Pipeline stage S1 (register): x, y, p, exact = (x*y)[PW-1:0].
- Pipeline stage S2 (register): ed = |p − exact|, computed at PW+1 bits; the result fits in PW bits.
- Pipeline stage S3 (statistics commit):
  - sum_ed += ed
  - err_cnt += (ed ≠ 0)
  - nz_cnt += (exact ≠ 0)
  - if ed > max_ed (strict): update max_ed, max_x, max_y, max_exact, max_approx. On a tie the first occurrence is kept.
- Sum width: ACCW cannot overflow at CNTW samples of PW-bit error. No saturation logic.
- The pipeline accepts a sample every cycle; there are no bubbles other than those in_valid introduces.

## Timing
- Reset values (rst_n = 0 at an edge): state IDLE; in_ready, busy, done = 0; all statistic outputs = 0; pipeline valids = 0.
- A reset mid-run aborts the run immediately. In-flight samples are discarded.
- Sample accepted at edge k: it is in S1 after edge k, in S2 after edge k+1, and its statistics are visible after edge k+2.
- done rises in the cycle after the last sample's statistics commit, i.e. after edge k_last+3. busy falls on the same edge.
- n_samples = 0: done = 1 one cycle after start; all outputs are 0.
- in_ready is combinational from state and counter only. It never depends on in_valid.
- Statistic outputs are stable whenever done = 1.

## Test plan
- n_samples=1, x=200, y=100, p=20000 → done after 4 cycles; sum_ed=0, err_cnt=0, nz_cnt=1, max_ed=0.
- n_samples=3: (10,10,90), (255,255,65000), (0,7,3) → sum_ed=10+25+3=38; err_cnt=3; nz_cnt=2; max_ed=25 with max_x=255, max_y=255, max_exact=65025, max_approx=65000.
- Tie: samples (4,4,14) then (2,3,4) → max_ed=2 keeps the first sample: max_x=4, max_y=4.
- n_samples=0 → done=1 one cycle after start; in_ready never asserts; all outputs are 0.
- Backpressure/gaps: n_samples=5 with in_valid toggling randomly → exactly 5 handshakes; in_ready=0 after the 5th. A start pulse mid-run has no effect.
- Reset mid-run: drive rst_n=0 after 2 of 5 samples → next cycle all outputs are 0 and state is IDLE. A new start with n_samples=1 completes normally.
